// File: rtl/distance_pkg.sv
`default_nettype none
// ============================================================================
// Module      : distance_pkg
// Description : Width helpers and tracker state encoding for distance_sq_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package distance_pkg;

    // Ceiling log2, returning 0 for n <= 1 so a single coordinate needs no tree level
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    function automatic int dist_width(input int coord_w, input int dim);
        return 2 * coord_w + clog2_f(dim);
    endfunction

    function automatic int pipe_latency(input int dim);
        return 2 + clog2_f(dim);
    endfunction

    typedef enum logic [0:0] {
        TRK_IDLE  = 1'b0,
        TRK_TRACK = 1'b1
    } trk_state_t;

endpackage
`default_nettype wire

// File: rtl/distance_sq_pipe_adder_tree.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_pipe
// Description : Registered pairwise reduction of N unsigned terms, one level per
//               stage, with valid and sideband carried alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_pipe
    import distance_pkg::*;
#(
    parameter int N    = 2,
    parameter int IN_W = 32,
    parameter int SB_W = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          en_in,
    input  logic                          valid_in,
    input  logic [N-1:0][IN_W-1:0]        data_in,
    input  logic [SB_W-1:0]               sb_in,
    output logic                          valid_out,
    output logic [IN_W+clog2_f(N)-1:0]    sum_out,
    output logic [SB_W-1:0]               sb_out
);

    localparam int LVLS  = clog2_f(N);
    localparam int OUT_W = IN_W + LVLS;
    localparam int NP    = 1 << LVLS;

    // Heap layout: node k has children 2k+1 and 2k+2; leaves occupy NP-1 .. 2*NP-2
    logic [OUT_W-1:0] w_node [2*NP-1];

    for (genvar j = 0; j < NP; j++) begin : g_leaf
        if (j < N) begin : g_used
            assign w_node[NP-1+j] = OUT_W'(data_in[j]);
        end else begin : g_pad
            assign w_node[NP-1+j] = '0;
        end
    end

    if (LVLS == 0) begin : g_flat
        assign valid_out = valid_in;
        assign sb_out    = sb_in;
    end else begin : g_tree
        logic [OUT_W-1:0] r_node [NP-1];
        logic [LVLS-1:0]  r_vld;
        logic [SB_W-1:0]  r_sb [LVLS];

        for (genvar k = 0; k < NP - 1; k++) begin : g_int
            assign w_node[k] = r_node[k];
        end

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                for (int k = 0; k < NP - 1; k++) r_node[k] <= '0;
                for (int l = 0; l < LVLS; l++) r_sb[l] <= '0;
                r_vld <= '0;
            end else if (en_in) begin
                for (int k = 0; k < NP - 1; k++) r_node[k] <= w_node[2*k+1] + w_node[2*k+2];
                r_vld[0] <= valid_in;
                r_sb[0]  <= sb_in;
                for (int l = 1; l < LVLS; l++) begin
                    r_vld[l] <= r_vld[l-1];
                    r_sb[l]  <= r_sb[l-1];
                end
            end
        end

        assign valid_out = r_vld[LVLS-1];
        assign sb_out    = r_sb[LVLS-1];
    end

    assign sum_out = w_node[0];

endmodule
`default_nettype wire

// File: rtl/distance_sq_pipe.sv
`default_nettype none
// ============================================================================
// Module      : distance_sq_pipe
// Description : Pipelined exact squared Euclidean distance between a held query
//               and one candidate vertex per cycle. DIST_MIN_TRACK_EN adds a
//               per-group running-minimum reporter on the output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module distance_sq_pipe
    import distance_pkg::*;
#(
    parameter int DIM     = 2,
    parameter int COORD_W = 16,
    parameter int TAG_W   = 8
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 query_load_in,
    input  logic [DIM-1:0][COORD_W-1:0]          query_pos_in,
    input  logic                                 vertex_valid_in,
    output logic                                 vertex_ready_out,
    input  logic [DIM-1:0][COORD_W-1:0]          vertex_pos_in,
    input  logic [TAG_W-1:0]                     vertex_tag_in,
`ifdef DIST_MIN_TRACK_EN
    input  logic                                 vertex_last_in,
    output logic                                 min_valid_out,
    output logic [2*COORD_W+clog2_f(DIM)-1:0]    min_dist_out,
    output logic [TAG_W-1:0]                     min_tag_out,
`endif
    output logic                                 dist_valid_out,
    input  logic                                 dist_ready_in,
    output logic [2*COORD_W+clog2_f(DIM)-1:0]    dist_sq_out,
    output logic [TAG_W-1:0]                     dist_tag_out
);

    localparam int DIST_W = dist_width(COORD_W, DIM);
    localparam int SQ_W   = 2 * COORD_W;
`ifdef DIST_MIN_TRACK_EN
    localparam int SB_W   = TAG_W + 1;
`else
    localparam int SB_W   = TAG_W;
`endif

    // |diff| <= 2^COORD_W - 1, so its square always fits in 2*COORD_W bits
    function automatic logic [SQ_W-1:0] square(input logic signed [COORD_W:0] d);
        logic signed [SQ_W+1:0] w_ext;
        w_ext = (SQ_W + 2)'(d);
        return SQ_W'(w_ext * w_ext);
    endfunction

    logic                          w_en;
    logic [SB_W-1:0]               w_sb_in;
    logic [SB_W-1:0]               w_out_sb;
    logic [DIM-1:0][COORD_W-1:0]   r_query;
    logic                          r_s1_valid;
    logic signed [COORD_W:0]       r_diff [DIM];
    logic [SB_W-1:0]               r_s1_sb;
    logic                          r_s2_valid;
    logic [DIM-1:0][SQ_W-1:0]      r_sq;
    logic [SB_W-1:0]               r_s2_sb;

    assign w_en             = !dist_valid_out || dist_ready_in;
    assign vertex_ready_out = w_en;

`ifdef DIST_MIN_TRACK_EN
    assign w_sb_in = {vertex_last_in, vertex_tag_in};
`else
    assign w_sb_in = vertex_tag_in;
`endif

    // Query loads ignore the stall; in-flight beats already captured their diffs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)            r_query <= '0;
        else if (query_load_in) r_query <= query_pos_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_sb    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_sb    <= '0;
            r_sq       <= '0;
            for (int i = 0; i < DIM; i++) r_diff[i] <= '0;
        end else if (w_en) begin
            r_s1_valid <= vertex_valid_in;
            r_s1_sb    <= w_sb_in;
            for (int i = 0; i < DIM; i++)
                r_diff[i] <= (COORD_W + 1)'($signed(r_query[i])) - (COORD_W + 1)'($signed(vertex_pos_in[i]));
            r_s2_valid <= r_s1_valid;
            r_s2_sb    <= r_s1_sb;
            for (int i = 0; i < DIM; i++) r_sq[i] <= square(r_diff[i]);
        end
    end

    adder_tree_pipe #(
        .N    (DIM),
        .IN_W (SQ_W),
        .SB_W (SB_W)
    ) u_tree (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (w_en),
        .valid_in  (r_s2_valid),
        .data_in   (r_sq),
        .sb_in     (r_s2_sb),
        .valid_out (dist_valid_out),
        .sum_out   (dist_sq_out),
        .sb_out    (w_out_sb)
    );

    assign dist_tag_out = w_out_sb[TAG_W-1:0];

`ifdef DIST_MIN_TRACK_EN
    logic              w_take;
    logic              w_out_last;
    logic              w_better;
    trk_state_t        r_trk_state, w_trk_nx;
    logic [DIST_W-1:0] r_run_dist, w_run_dist_nx;
    logic [TAG_W-1:0]  r_run_tag, w_run_tag_nx;
    logic              w_min_valid_nx;
    logic [DIST_W-1:0] w_min_dist_nx;
    logic [TAG_W-1:0]  w_min_tag_nx;

    assign w_take     = dist_valid_out && dist_ready_in;
    assign w_out_last = w_out_sb[TAG_W];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_trk_state   <= TRK_IDLE;
            r_run_dist    <= '0;
            r_run_tag     <= '0;
            min_valid_out <= 1'b0;
            min_dist_out  <= '0;
            min_tag_out   <= '0;
        end else begin
            r_trk_state   <= w_trk_nx;
            r_run_dist    <= w_run_dist_nx;
            r_run_tag     <= w_run_tag_nx;
            min_valid_out <= w_min_valid_nx;
            min_dist_out  <= w_min_dist_nx;
            min_tag_out   <= w_min_tag_nx;
        end
    end

    // Strict less-than keeps the earliest beat on ties
    always_comb begin
        w_trk_nx       = r_trk_state;
        w_run_dist_nx  = r_run_dist;
        w_run_tag_nx   = r_run_tag;
        w_min_valid_nx = 1'b0;
        w_min_dist_nx  = min_dist_out;
        w_min_tag_nx   = min_tag_out;
        w_better       = (r_trk_state == TRK_IDLE) || (dist_sq_out < r_run_dist);
        if (w_take) begin
            if (w_better) begin
                w_run_dist_nx = dist_sq_out;
                w_run_tag_nx  = dist_tag_out;
            end
            if (w_out_last) begin
                w_min_valid_nx = 1'b1;
                w_min_dist_nx  = w_run_dist_nx;
                w_min_tag_nx   = w_run_tag_nx;
                w_trk_nx       = TRK_IDLE;
            end else begin
                w_trk_nx       = TRK_TRACK;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/distance_sq_pipe.md
Name: distance_sq_pipe

Overview:
- Fully pipelined squared-Euclidean-distance engine for the nearest-neighbour search datapath.
- Holds one query vector and accepts one candidate vertex vector per cycle, all DIM coordinates in a single beat.
- Emits exact sum((q_i - p_i)^2) with a passthrough tag.
- Valid/ready on both sides with full backpressure; sits between the vertex fetch stream and the min-search/sorting stage.

Parameters:
- DIM, 2, number of coordinates per vector (>=1, any value; non-power-of-2 zero-padded in tree).
- COORD_W, 16, signed coordinate width.
- TAG_W, 8, width of vertex tag carried alongside each beat.
- Derived, not overridable: LVLS = clog2(DIM) (0 for DIM=1); DIST_W = 2*COORD_W + LVLS; LAT = 2 + LVLS.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset, asynchronous assert, active-low.
- query_load_in  input  1  load query register from query_pos_in this cycle.
- query_pos_in  input  DIM x COORD_W signed  query coordinates.
- vertex_valid_in  input  1  vertex beat valid.
- vertex_ready_out  output  1  engine can accept beat.
- vertex_pos_in  input  DIM x COORD_W signed  vertex coordinates.
- vertex_tag_in  input  TAG_W  vertex identifier.
- dist_valid_out  output  1  result valid.
- dist_ready_in  input  1  downstream accepts result.
- dist_sq_out  output  DIST_W unsigned  squared distance.
- dist_tag_out  output  TAG_W  tag of that result.

Behaviour:
- Reset: all stage valid bits, dist_valid_out, dist_sq_out, dist_tag_out and the query register clear to 0. In-flight beats are discarded; no partial result is emitted after reset release.
- Global stall: en = !dist_valid_out || dist_ready_in.
  - vertex_ready_out = en (combinational).
  - All pipeline registers, including valid bits, advance only when en=1.
  - When en=0, everything holds and dist_* stay stable.
- Accept: a beat is taken when vertex_valid_in && vertex_ready_out.
- Pipeline:
  - S1 registers diff_i = q_i - p_i, signed COORD_W+1.
  - S2 registers sq_i = diff_i*diff_i, unsigned 2*COORD_W.
  - Then LVLS registered pairwise adder levels, each 1 bit wider; missing leaves are 0. The final level is the output register.
  - With DIM=1, S2 is the output register.
- Latency: the result appears LAT cycles after acceptance with no stall (DIM=2: 3, DIM=3/4: 4). Throughput is 1 result/cycle sustained.
- Arithmetic is exact: no truncation or saturation for any inputs, including -2^(COORD_W-1) vs 2^(COORD_W-1)-1.
- Query register:
  - Updated on any cycle with query_load_in=1, independent of en.
  - A beat accepted in the same cycle uses the OLD query.
  - Beats already in flight are unaffected, because the query is consumed at S1.
- Ordering: results leave strictly in acceptance order. Tags stay aligned through stalls.
- Bubbles: invalid stages still shift when en=1; bubbles are not collapsed.

Optional Feature:
- Macro DIST_MIN_TRACK_EN.
- Defined: adds ports vertex_last_in (input 1, rides with the beat), min_valid_out (output 1), min_dist_out (DIST_W), min_tag_out (TAG_W).
  - Tracks a running minimum over output beats as they are consumed (dist_valid_out && dist_ready_in).
  - Ties keep the earliest beat.
  - On consumption of the beat carrying last, min_valid_out pulses 1 cycle with the group minimum (including that beat), and the tracker re-arms for the next group.
  - A single-beat group reports that beat. Reset clears the tracker and min outputs to 0.
- Undefined: those ports and that logic do not exist; the core is unchanged.

Decomposition:
- Package distance_pkg:
  - clog2-style width functions for DIST_W/LAT.
  - coord_t/dist_t style typedefs parametrised via localparams in the module.
  - Tracker state encoding: IDLE/TRACK.
- One sub-module: adder_tree_pipe (parameters N, IN_W; pipelined reduction with enable and valid/tag sideband), instantiated once for the tree levels.

Test Plan:
- DIM=2, COORD_W=16: q=(3,4), p=(0,0), tag=5, dist_ready_in=1 -> dist_sq_out=25, dist_tag_out=5, exactly 3 cycles after accept.
- DIM=3: q=(-32768,-32768,-32768), p=(32767,32767,32767) -> 3*65535^2 = 12884508675 exact in 34 bits, latency 4.
- Stream of 8 back-to-back beats with dist_ready_in low for cycles 4-6 -> vertex_ready_out low the same cycles; all 8 results in order, tags 0..7, none lost or duplicated, outputs stable while stalled.
- query_load_in to q=(1,1) in the same cycle as accepting p=(0,0) under old q=(0,0) -> that result 0; the next beat p=(0,0) gives 2.
- Reset asserted asynchronously with 2 beats in flight -> dist_valid_out 0 immediately; after release no stale result appears; next beat latency is nominal.
- DIST_MIN_TRACK_EN, group dists 9,4,4,16 with last on the 4th beat (tags 1-4) -> min_valid_out single pulse, min_dist_out=4, min_tag_out=2.
